// File: rtl/inst_aligner_pkg.sv
// inst_aligner_pkg
//   Shared definitions for the instruction aligner: FSM state encoding,
//   the "full-length instruction" opcode marker and a small classifier.
package inst_aligner_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Low two bits of a 32-bit (uncompressed) instruction.
  localparam logic [1:0] C_OPCODE_FULL = 2'b11;

  // True when the halfword is the low half of a 32-bit instruction.
  function automatic logic is_full(input logic [15:0] half);
    return half[1:0] == C_OPCODE_FULL;
  endfunction

endpackage

// File: rtl/inst_aligner.sv
// inst_aligner
//   Turns a stream of little-endian 32-bit instruction words into a stream
//   of individual 16/32-bit instructions with their PCs. Keeps one upper
//   halfword as a residual so 32-bit instructions may straddle word
//   boundaries. At most one memory request is outstanding at any time.
//
// Ports
//   clk               in   clock, rising edge
//   rst               in   asynchronous active-high reset
//   mem_req           out  one-cycle word fetch request
//   mem_addr          out  word-aligned fetch address
//   mem_valid         in   fetch response valid
//   mem_data          in   fetch response word
//   redirect          in   flush and restart at redirect_pc (highest priority)
//   redirect_pc       in   new PC, bit 0 ignored
//   out_valid         out  instruction outputs valid
//   out_ready         in   downstream accepts the instruction
//   out_instr         out  instruction; compressed ones are zero-extended,
//                          bits [15:0] feed the decompressor
//   out_is_compressed out  out_instr[1:0] != 2'b11
//   out_pc            out  address of out_instr
module inst_aligner
  import inst_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_is_compressed,
  output logic [31:0] out_pc
);

  state_t      r_state,      w_state;
  logic [31:0] r_fetch_addr, w_fetch_addr;
  logic        r_skip_low,   w_skip_low;
  logic [15:0] r_res,        w_res;
  logic        r_res_v,      w_res_v;
  logic        r_drop,       w_drop;
  logic [31:0] r_instr,      w_instr;
  logic        r_is_c,       w_is_c;
  logic [31:0] r_pc,         w_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_fetch_addr <= {RESET_PC[31:2], 2'b00};
      r_skip_low   <= RESET_PC[1];
      r_res        <= '0;
      r_res_v      <= 1'b0;
      r_drop       <= 1'b0;
      r_instr      <= '0;
      r_is_c       <= 1'b0;
      r_pc         <= RESET_PC;
    end else begin
      r_state      <= w_state;
      r_fetch_addr <= w_fetch_addr;
      r_skip_low   <= w_skip_low;
      r_res        <= w_res;
      r_res_v      <= w_res_v;
      r_drop       <= w_drop;
      r_instr      <= w_instr;
      r_is_c       <= w_is_c;
      r_pc         <= w_pc;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_fetch_addr = r_fetch_addr;
    w_skip_low   = r_skip_low;
    w_res        = r_res;
    w_res_v      = r_res_v;
    w_drop       = r_drop;
    w_instr      = r_instr;
    w_is_c       = r_is_c;
    w_pc         = r_pc;

    // A response owed to a request from before a redirect is swallowed
    // here; the FSM never reaches S_WAIT while the drop flag is set.
    if (r_drop && mem_valid) begin
      w_drop = 1'b0;
    end else if (redirect && (r_state == S_WAIT) && !mem_valid) begin
      w_drop = 1'b1;
    end

    if (redirect) begin
      w_state      = S_REQ;
      w_res_v      = 1'b0;
      w_pc         = redirect_pc & ~32'd1;
      w_fetch_addr = redirect_pc & ~32'd3;
      w_skip_low   = redirect_pc[1];
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (!r_drop) w_state = S_WAIT;
        end
        S_WAIT: begin
          if (mem_valid) begin
            w_fetch_addr = r_fetch_addr + 32'd4;
            w_res        = mem_data[31:16];
            if (r_skip_low) begin
              // Entered mid-word: only the upper halfword is useful.
              w_skip_low = 1'b0;
              if (!is_full(mem_data[31:16])) begin
                w_instr = {16'h0000, mem_data[31:16]};
                w_is_c  = 1'b1;
                w_res_v = 1'b0;
                w_state = S_OUT;
              end else begin
                w_res_v = 1'b1;
                w_state = S_REQ;
              end
            end else if (r_res_v) begin
              w_instr = {mem_data[15:0], r_res};
              w_is_c  = 1'b0;
              w_res_v = 1'b1;
              w_state = S_OUT;
            end else if (!is_full(mem_data[15:0])) begin
              w_instr = {16'h0000, mem_data[15:0]};
              w_is_c  = 1'b1;
              w_res_v = 1'b1;
              w_state = S_OUT;
            end else begin
              w_instr = mem_data;
              w_is_c  = 1'b0;
              w_res_v = 1'b0;
              w_state = S_OUT;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            w_pc = r_pc + (r_is_c ? 32'd2 : 32'd4);
            if (r_res_v && !is_full(r_res)) begin
              w_instr = {16'h0000, r_res};
              w_is_c  = 1'b1;
              w_res_v = 1'b0;
            end else begin
              w_state = S_REQ;
            end
          end
        end
        default: w_state = S_REQ;
      endcase
    end
  end

  // Suppressed under redirect so a request is never orphaned by the flush.
  assign mem_req           = (r_state == S_REQ) && !r_drop && !redirect && !rst;
  assign mem_addr          = r_fetch_addr;
  assign out_valid         = (r_state == S_OUT);
  assign out_instr         = r_instr;
  assign out_is_compressed = r_is_c;
  assign out_pc            = r_pc;

endmodule

// File: tb/tb_inst_aligner.sv
module tb_inst_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_is_compressed;
  logic [31:0] out_pc;

  inst_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_is_compressed(out_is_compressed),
    .out_pc(out_pc)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Memory contents: explicit overrides, otherwise a fixed hash of the address.
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] x;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    x = a ^ (a >> 7);
    x = x * 32'h9E37_79B1;
    x = x ^ (x >> 15);
    x = x * 32'h85EB_CA6B;
    x = x ^ (x >> 13);
    return x;
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] p);
    logic [31:0] w;
    w = word_at({p[31:2], 2'b00});
    return p[1] ? w[31:16] : w[15:0];
  endfunction

  // Instruction-stream reference: the instruction starting at halfword p.
  function automatic void model_peek(input logic [31:0] p,
                                     output logic [31:0] instr,
                                     output logic c);
    logic [15:0] lo;
    lo = half_at(p);
    if (lo[1:0] != 2'b11) begin
      instr = {16'h0000, lo};
      c = 1'b1;
    end else begin
      instr = {half_at(p + 32'd2), lo};
      c = 1'b0;
    end
  endfunction

  // Memory responder: records every request, answers after a delay.
  logic [31:0] req_q [$];
  bit          pend = 0;
  bit          viol = 0;
  logic [31:0] rsp_addr;
  int          rsp_dly = 0;
  int          fixed_dly = -1;

  initial begin
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (pend && !rst) begin
        if (rsp_dly == 0) begin
          mem_valid = 1'b1;
          mem_data  = word_at(rsp_addr);
          pend      = 0;
        end else begin
          rsp_dly--;
        end
      end
      #2;
      if (rst) begin
        pend = 0;
        viol = 0;
        mem_valid = 1'b0;
        req_q.delete();
      end else if (mem_req) begin
        if (pend) viol = 1;
        pend     = 1;
        rsp_addr = mem_addr;
        rsp_dly  = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
        req_q.push_back(mem_addr);
      end
    end
  end

  logic [31:0] got_i [$];
  logic [31:0] got_p [$];
  logic        got_c [$];

  task automatic apply_reset();
    rst = 1'b1;
    redirect = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic collect(input int cycles);
    got_i.delete(); got_p.delete(); got_c.delete();
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got_i.push_back(out_instr);
        got_p.push_back(out_pc);
        got_c.push_back(out_is_compressed);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", mem_req);
    else n_pass++;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_total++;
    if ({out_instr, out_is_compressed} !== 33'h0)
      $display("FAIL reset_instr: got %h/%b expected 0/0", out_instr, out_is_compressed);
    else n_pass++;
    n_total++;
    if ({out_pc, mem_addr} !== 64'h0)
      $display("FAIL reset_pc_addr: got %h/%h expected 0/0", out_pc, mem_addr);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_compressed_pair();
    mem_ovr.delete();
    mem_ovr[32'h0] = 32'h04C5_0001;
    apply_reset();
    out_ready = 1'b1;
    collect(16);
    n_total++;
    if (got_i.size() < 2) $display("FAIL pair_count: got %0d expected >=2", got_i.size());
    else n_pass++;
    n_total++;
    if ({got_i[0], got_c[0], got_p[0]} !== {32'h1, 1'b1, 32'h0})
      $display("FAIL pair_first: got %h/%b/%h expected 00000001/1/00000000", got_i[0], got_c[0], got_p[0]);
    else n_pass++;
    n_total++;
    if ({got_i[1], got_c[1], got_p[1]} !== {32'h4C5, 1'b1, 32'h2})
      $display("FAIL pair_second: got %h/%b/%h expected 000004c5/1/00000002", got_i[1], got_c[1], got_p[1]);
    else n_pass++;
    n_total++;
    if (req_q.size() < 2 || req_q[0] !== 32'h0 || req_q[1] !== 32'h4)
      $display("FAIL pair_fetch: got %0d reqs first %h second %h expected 0,4", req_q.size(), req_q[0], req_q[1]);
    else n_pass++;
  endtask

  task automatic test_full_word();
    mem_ovr.delete();
    mem_ovr[32'h0] = 32'h0050_0093;
    apply_reset();
    out_ready = 1'b1;
    collect(14);
    n_total++;
    if (got_i.size() < 1 || {got_i[0], got_c[0], got_p[0]} !== {32'h0050_0093, 1'b0, 32'h0})
      $display("FAIL full_out: got %h/%b/%h expected 00500093/0/00000000", got_i[0], got_c[0], got_p[0]);
    else n_pass++;
    n_total++;
    if (req_q.size() < 2 || req_q[1] !== 32'h4)
      $display("FAIL full_next_fetch: got %h expected 00000004", req_q[1]);
    else n_pass++;
  endtask

  task automatic test_spanning();
    mem_ovr.delete();
    mem_ovr[32'h0] = 32'h0093_0001;
    mem_ovr[32'h4] = 32'h1234_0050;
    apply_reset();
    out_ready = 1'b1;
    collect(24);
    n_total++;
    if (got_i.size() < 3) $display("FAIL span_count: got %0d expected >=3", got_i.size());
    else n_pass++;
    n_total++;
    if ({got_i[0], got_p[0]} !== {32'h1, 32'h0})
      $display("FAIL span_first: got %h/%h expected 00000001/00000000", got_i[0], got_p[0]);
    else n_pass++;
    n_total++;
    if ({got_i[1], got_c[1], got_p[1]} !== {32'h0050_0093, 1'b0, 32'h2})
      $display("FAIL span_straddle: got %h/%b/%h expected 00500093/0/00000002", got_i[1], got_c[1], got_p[1]);
    else n_pass++;
    // 0x1234 has low bits 00, so it is itself a compressed instruction.
    n_total++;
    if ({got_i[2], got_c[2], got_p[2]} !== {32'h1234, 1'b1, 32'h6})
      $display("FAIL span_residual: got %h/%b/%h expected 00001234/1/00000006", got_i[2], got_c[2], got_p[2]);
    else n_pass++;
    n_total++;
    if (req_q.size() < 3 || req_q[2] !== 32'h8)
      $display("FAIL span_fetch: got %h expected 00000008", req_q[2]);
    else n_pass++;
  endtask

  task automatic test_redirect_mid_word();
    mem_ovr.delete();
    mem_ovr[32'h100] = 32'h04C5_FFFF;
    apply_reset();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0102;
    out_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    n_total++;
    if ({out_valid, out_pc, mem_addr} !== {1'b0, 32'h102, 32'h100})
      $display("FAIL redir_state: got %b/%h/%h expected 0/00000102/00000100", out_valid, out_pc, mem_addr);
    else n_pass++;
    collect(16);
    n_total++;
    if (got_i.size() < 1 || {got_i[0], got_c[0], got_p[0]} !== {32'h4C5, 1'b1, 32'h102})
      $display("FAIL redir_out: got %h/%b/%h expected 000004c5/1/00000102", got_i[0], got_c[0], got_p[0]);
    else n_pass++;
    n_total++;
    if (req_q.size() < 2 || req_q[0] !== 32'h100 || req_q[1] !== 32'h104)
      $display("FAIL redir_fetch: got %h,%h expected 00000100,00000104", req_q[0], req_q[1]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] s_i, s_p;
    logic        s_c;
    bit          seen;
    mem_ovr.delete();
    mem_ovr[32'h0] = 32'h04C5_0001;
    apply_reset();
    out_ready = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    n_total++;
    if (!seen) $display("FAIL stall_timeout: got no out_valid expected out_valid within 20 cycles");
    else n_pass++;
    s_i = out_instr; s_p = out_pc; s_c = out_is_compressed;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if ({out_valid, out_instr, out_pc, out_is_compressed} !== {1'b1, s_i, s_p, s_c})
        $display("FAIL stall_hold: got %b/%h/%h/%b expected 1/%h/%h/%b",
                 out_valid, out_instr, out_pc, out_is_compressed, s_i, s_p, s_c);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_total++;
    if ({out_valid, out_instr, out_pc} !== {1'b1, 32'h4C5, 32'h2})
      $display("FAIL stall_consume: got %b/%h/%h expected 1/000004c5/00000002", out_valid, out_instr, out_pc);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({out_valid, out_pc} !== {1'b1, 32'h2})
      $display("FAIL stall_single: got %b/%h expected 1/00000002", out_valid, out_pc);
    else n_pass++;
  endtask

  task automatic test_drop_stale();
    mem_ovr.delete();
    mem_ovr[32'h0]   = 32'hDEAD_BEEF;
    mem_ovr[32'h200] = 32'h0000_4501;
    fixed_dly = 2;
    apply_reset();
    out_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect = 1'b0;
    collect(20);
    fixed_dly = -1;
    n_total++;
    if (got_i.size() < 1 || {got_i[0], got_c[0], got_p[0]} !== {32'h4501, 1'b1, 32'h200})
      $display("FAIL drop_first_out: got %h/%b/%h expected 00004501/1/00000200", got_i[0], got_c[0], got_p[0]);
    else n_pass++;
    n_total++;
    if (req_q.size() < 3 || req_q[0] !== 32'h0 || req_q[1] !== 32'h200 || req_q[2] !== 32'h204)
      $display("FAIL drop_fetch: got %0d reqs %h,%h,%h expected 0,200,204", req_q.size(), req_q[0], req_q[1], req_q[2]);
    else n_pass++;
    n_total++;
    if (viol !== 1'b0) $display("FAIL drop_outstanding: got overlap %b expected 0", viol);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    logic [31:0] m_pc, m_exp, a, ei, s_i, s_p, rpc;
    logic        ec, s_c, prev_stall;
    mem_ovr.delete();
    apply_reset();
    m_pc = 32'h0;
    m_exp = 32'h0;
    prev_stall = 1'b0;
    s_i = '0; s_p = '0; s_c = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      while (req_q.size() > 0) begin
        a = req_q.pop_front();
        n_total++;
        if (a !== m_exp) $display("FAIL rnd_fetch_addr: got %h expected %h", a, m_exp);
        else n_pass++;
        m_exp = m_exp + 32'd4;
      end
      if (prev_stall) begin
        n_total++;
        if ({out_valid, out_instr, out_pc, out_is_compressed} !== {1'b1, s_i, s_p, s_c})
          $display("FAIL rnd_stall_hold: got %b/%h/%h/%b expected 1/%h/%h/%b",
                   out_valid, out_instr, out_pc, out_is_compressed, s_i, s_p, s_c);
        else n_pass++;
      end
      if (out_valid) begin
        model_peek(m_pc, ei, ec);
        n_total++;
        if ({out_instr, out_is_compressed, out_pc} !== {ei, ec, m_pc})
          $display("FAIL rnd_instr: got %h/%b/%h expected %h/%b/%h",
                   out_instr, out_is_compressed, out_pc, ei, ec, m_pc);
        else n_pass++;
      end
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        else rpc = $urandom_range(0, 1023);
        redirect = 1'b1;
        redirect_pc = rpc;
        out_ready = $urandom_range(0, 1) != 0;
        m_pc = rpc & ~32'd1;
        m_exp = rpc & ~32'd3;
        prev_stall = 1'b0;
      end else begin
        redirect = 1'b0;
        out_ready = $urandom_range(0, 3) != 0;
        if (out_valid && out_ready) begin
          model_peek(m_pc, ei, ec);
          m_pc = m_pc + (ec ? 32'd2 : 32'd4);
        end
        prev_stall = out_valid && !out_ready;
        s_i = out_instr; s_p = out_pc; s_c = out_is_compressed;
      end
    end
    redirect = 1'b0;
    out_ready = 1'b0;
    n_total++;
    if (viol !== 1'b0) $display("FAIL rnd_outstanding: got overlap %b expected 0", viol);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_compressed_pair();
    test_full_word();
    test_spanning();
    test_redirect_mid_word();
    test_backpressure();
    test_drop_stale();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
